// File: rtl/mmu_job_arbiter.sv
// mmu_job_arbiter: round-robin sharing of the 2x2 systolic MMU between two
// requesters; serializes operand bytes in and result bytes out per job.
module mmu_job_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic        mmu_rst,
  output logic        load_en,
  output logic        load_sel_ab,
  output logic [1:0]  load_index,
  output logic [7:0]  in_data,
  output logic        output_en,
  output logic [1:0]  output_sel,
  input  logic [7:0]  out_data,
  input  logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    r_state;
  logic          r_last;
  logic          r_owner;
  logic          r_err;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_res;
  logic [2:0]    r_beat;
  logic [TW-1:0] r_tmo;

  logic w_any;
  logic w_grant;
  logic w_accept;
  logic w_resp_hs;

  assign w_any = |req_valid;

  // On a tie the requester not served last wins.
  assign w_grant = (req_valid == 2'b11) ? ~r_last : req_valid[1];

  assign w_accept  = (r_state == S_IDLE) && w_any && !rst;
  assign w_resp_hs = (r_state == S_RESP) && resp_ready[r_owner];

  assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_beat  <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant ? req_a1 : req_a0;
            r_b     <= w_grant ? req_b1 : req_b0;
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_beat  <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_beat <= r_beat + 3'd1;
          if (r_beat == 3'd7) begin
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            r_beat  <= '0;
            r_state <= S_READ;
          end else if (r_tmo == TMO_MAX) begin
            r_err   <= 1'b1;
            r_res   <= '0;
            r_state <= S_RESP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_READ: begin
          r_res[{r_beat[1:0], 3'b000} +: 8] <= out_data;
          r_beat <= r_beat + 3'd1;
          if (r_beat[1:0] == 2'd3) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    load_en     = 1'b0;
    load_sel_ab = 1'b0;
    load_index  = 2'd0;
    in_data     = 8'd0;
    output_en   = 1'b0;
    output_sel  = 2'd0;
    if (r_state == S_LOAD) begin
      load_en     = 1'b1;
      load_sel_ab = r_beat[2];
      load_index  = r_beat[1:0];
      in_data     = r_beat[2] ? r_b[{r_beat[1:0], 3'b000} +: 8]
                              : r_a[{r_beat[1:0], 3'b000} +: 8];
    end
    if (r_state == S_READ) begin
      output_en  = 1'b1;
      output_sel = r_beat[1:0];
    end
  end

  assign resp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01)
                                          : 2'b00;
  assign resp_data  = r_res;
  assign resp_err   = r_err;
  assign busy       = (r_state != S_IDLE);
  assign mmu_rst    = rst | (r_state == S_CLEAR);

endmodule

// File: tb/tb_mmu_job_arbiter.sv
// tb_mmu_job_arbiter: scoreboard bench with a stub MMU and a
// job-level reference model of arbitration and matrix product.
module tb_mmu_job_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        resp_err, busy, mmu_rst;
  logic        load_en, load_sel_ab, output_en, done;
  logic [1:0]  load_index, output_sel;
  logic [7:0]  in_data, out_data;

  mmu_job_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .mmu_rst(mmu_rst),
    .load_en(load_en), .load_sel_ab(load_sel_ab),
    .load_index(load_index), .in_data(in_data),
    .output_en(output_en), .output_sel(output_sel),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stub MMU: latches loaded bytes, raises done after stub_lat cycles.
  int          stub_lat = 0;
  logic        stub_hang = 1'b0;
  logic [7:0]  s_a [4];
  logic [7:0]  s_b [4];
  logic [7:0]  s_ld;
  int          s_cnt;
  logic [7:0]  s_acc;

  always @(posedge clk) begin
    if (mmu_rst) begin
      s_ld  <= 8'h00;
      s_cnt <= 0;
    end else begin
      if (load_en) begin
        if (load_sel_ab) s_b[load_index] <= in_data;
        else             s_a[load_index] <= in_data;
        s_ld[{load_sel_ab, load_index}] <= 1'b1;
      end
      if (s_ld == 8'hff && s_cnt < 1000) s_cnt <= s_cnt + 1;
    end
  end

  assign done = (s_ld == 8'hff) && (s_cnt >= stub_lat) && !stub_hang;

  always_comb begin
    s_acc = 8'h00;
    for (int k = 0; k < 2; k++)
      s_acc = s_acc + 8'(s_a[2 * int'(output_sel[1]) + k]
                       * s_b[int'(output_sel[0]) + 2 * k]);
  end
  assign out_data = s_acc;

  // Reference: C = A x B, row-major 2x2, each element mod 256.
  function automatic logic [31:0] ref_mm(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] c;
    int sum;
    c = '0;
    for (int r = 0; r < 2; r++)
      for (int cc = 0; cc < 2; cc++) begin
        sum = 0;
        for (int k = 0; k < 2; k++)
          sum += int'(a[8*(2*r+k) +: 8]) * int'(b[8*(2*k+cc) +: 8]);
        c[8*(2*r+cc) +: 8] = sum[7:0];
      end
    return c;
  endfunction

  typedef struct {
    logic        g;
    logic [31:0] data;
    logic        err;
    logic        lat0;
  } exp_t;

  exp_t        exp_q [$];
  int          cyc = 0;
  int          rsp_cnt = 0;
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic        clr_pend = 1'b0;
  logic        first_seen = 1'b0;
  int          t_acc = 0;
  logic [31:0] last_rsp = '0;
  logic        last_owner = 1'b0;
  int          grant_log [$];
  logic [10:0] load_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic mb;
    logic g;
    exp_t e;
    int   lat;
    if (rst) begin
      chk("mmu_rst_in_reset", 32'(mmu_rst), 32'd1);
      chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      exp_q.delete();
      m_busy   = 1'b0;
      m_last   = 1'b1;
      clr_pend = 1'b0;
    end else begin
      mb = m_busy;
      chk("busy", 32'(busy), 32'(mb));
      if (clr_pend) begin
        chk("clear_mmu_rst", 32'(mmu_rst), 32'd1);
        clr_pend = 1'b0;
      end
      if (load_en) load_log.push_back({load_sel_ab, load_index, in_data});
      if (mb && exp_q.size() > 0 && exp_q[0].err)
        chk("no_read_on_timeout", 32'(output_en), 32'd0);
      if (resp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("resp_valid", 32'(resp_valid), e.g ? 32'd2 : 32'd1);
          chk("resp_data", resp_data, e.data);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          if (!first_seen) begin
            first_seen = 1'b1;
            lat = cyc - t_acc;
            if (e.err)       chk("lat_timeout", lat, 9 + TO);
            else if (e.lat0) chk("lat_min", lat, 14);
            else             chk("lat_ge_min", 32'(lat >= 14), 32'd1);
          end
          if ((resp_valid & resp_ready) != 2'b00) begin
            void'(exp_q.pop_front());
            last_rsp   = resp_data;
            last_owner = e.g;
            rsp_cnt++;
            m_busy = 1'b0;
          end
        end
      end
      if (!mb && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        chk("grant", 32'(req_ready), g ? 32'd2 : 32'd1);
        e.g    = g;
        e.err  = stub_hang;
        e.lat0 = (stub_lat == 0);
        e.data = stub_hang ? 32'd0
                 : (g ? ref_mm(req_a1, req_b1) : ref_mm(req_a0, req_b0));
        exp_q.push_back(e);
        m_busy     = 1'b1;
        m_last     = g;
        clr_pend   = 1'b1;
        t_acc      = cyc + 1;
        first_seen = 1'b0;
        grant_log.push_back(int'(g));
        load_log.delete();
      end else if (mb && req_valid != 2'b00) begin
        chk("no_grant_while_busy", 32'(req_ready), 32'd0);
      end
    end
  end

  int         rr_mode = 2;
  logic [1:0] bp_val = 2'b00;
  int         keep [2] = '{0, 0};

  task automatic step();
    logic [1:0] got;
    @(negedge clk);
    got = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (got[i]) begin
        if (keep[i] > 0) keep[i]--;
        else req_valid[i] = 1'b0;
      end
    case (rr_mode)
      0:       resp_ready = 2'($urandom_range(0, 3));
      1:       resp_ready = bp_val;
      default: resp_ready = 2'b11;
    endcase
  endtask

  task automatic issue(input int i, input logic [31:0] a,
                       input logic [31:0] b);
    if (i == 0) begin req_a0 = a; req_b0 = b; end
    else        begin req_a1 = a; req_b1 = b; end
    req_valid[i] = 1'b1;
  endtask

  task automatic drain(input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk("drain_responses", rsp_cnt, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [31:0] a, b;
    logic [10:0] ld;
    logic [1:0]  mask;

    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_en", 32'(load_en), 0);
    chk("rst_output_en", 32'(output_en), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mmu_rst_low", 32'(mmu_rst), 0);
    @(posedge clk);
    #1;

    // Single job, minimum latency
    a = 32'h01000001; b = 32'h04030201;
    stub_lat = 0; rr_mode = 2;
    base = rsp_cnt;
    issue(0, a, b);
    drain(base + 1, 100);
    chk("single_data", last_rsp, 32'h04030201);
    chk("single_owner", 32'(last_owner), 0);
    chk("load_beats", load_log.size(), 8);
    for (int k = 0; k < 8 && k < load_log.size(); k++) begin
      ld[10]  = (k >= 4);
      ld[9:8] = 2'(k % 4);
      ld[7:0] = (k < 4) ? a[8*(k%4) +: 8] : b[8*(k%4) +: 8];
      chk("load_beat", 32'(load_log[k]), 32'(ld));
    end

    // Tie from reset
    rst = 1'b1;
    grant_log.delete();
    issue(0, 32'h01000001, 32'h04030201);
    issue(1, 32'h02000002, 32'h01010101);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base = rsp_cnt;
    drain(base + 2, 100);
    chk("tie_grants", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++)
      chk("tie_order", grant_log[i], i);
    chk("tie_r1_data", last_rsp, 32'h02020202);

    // Fairness with requester 0 held valid
    grant_log.delete();
    base = rsp_cnt;
    keep[0] = 1;
    stub_lat = 3;
    issue(0, 32'h11223344, 32'h55667788);
    repeat (3) step();
    issue(1, 32'h0a0b0c0d, 32'h01020304);
    drain(base + 3, 200);
    chk("fair_grants", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      chk("fair_order", grant_log[i], i % 2);

    // Timeout, then a normal job after it
    base = rsp_cnt;
    stub_hang = 1'b1;
    issue(0, $urandom, $urandom);
    drain(base + 1, 200);
    stub_hang = 1'b0;
    stub_lat = 0;
    issue(1, $urandom, $urandom);
    drain(base + 2, 200);

    // Backpressure with a pending request on the other side
    base = rsp_cnt;
    rr_mode = 1; bp_val = 2'b00;
    issue(0, $urandom, $urandom);
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    issue(1, $urandom, $urandom);
    n = 0;
    while (resp_valid == 2'b00 && n < 100) begin step(); n++; end
    chk("bp_resp_seen", 32'(resp_valid), 32'd1);
    bp_val = 2'b10;
    repeat (10) step();
    chk("bp_wrong_ready_ignored", rsp_cnt, base);
    bp_val = 2'b01;
    drain(base + 1, 20);
    rr_mode = 2;
    drain(base + 2, 100);

    // Reset during load beat 4
    base = rsp_cnt;
    issue(0, $urandom, $urandom);
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(load_en && !load_sel_ab && load_index == 2'd3) && n < 50);
    chk("reached_beat3", n < 50, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_resp_valid", 32'(resp_valid), 0);
    chk("rr_load_en", 32'(load_en), 0);
    chk("rr_output_en", 32'(output_en), 0);
    chk("rr_resp_err", 32'(resp_err), 0);
    chk("rr_resp_data", resp_data, 0);
    repeat (20) step();
    chk("rr_no_resp", rsp_cnt, base);
    issue(1, 32'h01000001, 32'h0d0c0b0a);
    drain(base + 1, 100);
    chk("rr_fresh_data", last_rsp, 32'h0d0c0b0a);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      base = rsp_cnt;
      mask = 2'($urandom_range(1, 3));
      stub_lat = $urandom_range(0, 12);
      stub_hang = ($urandom_range(0, 7) == 0);
      rr_mode = 0;
      for (int i = 0; i < 2; i++)
        if (mask[i]) issue(i, $urandom, $urandom);
      drain(base + $countones(mask), 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_job_arbiter.md
# mmu_job_arbiter

Shares the 2×2 systolic matrix-multiply unit and its byte-serial load/output controller between two requesters. Each requester submits a whole job: packed A and B operands, 4 bytes each. The arbiter grants jobs round-robin, clears the multiply unit, serializes the 8 operand bytes into the controller, waits for `done`, reads back the 4 result bytes and returns them on a per-requester response handshake. It sits between the host-side request logic and the controller's load/output pins.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before the job is aborted with an error.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 2: per-requester job request.
- `req_ready` out 2: one-hot accept pulse; operands are captured on that edge.
- `req_a0`, `req_a1` in 32: A operand of requester 0/1; byte i = `[8i+:8]`.
- `req_b0`, `req_b1` in 32: B operand of requester 0/1, same packing.
- `resp_valid` out 2: one-hot, marks the owning requester.
- `resp_ready` in 2: per-requester response accept.
- `resp_data` out 32: result; byte i = C element i.
- `resp_err` out 1: job timed out; `resp_data` = 0.
- `busy` out 1: high in any state other than IDLE.
- `mmu_rst` out 1: reset to the controller and multiply unit.
- `load_en` out 1, `load_sel_ab` out 1 (0=A, 1=B), `load_index` out 2, `in_data` out 8: controller load port.
- `output_en` out 1, `output_sel` out 2: controller readout select.
- `out_data` in 8: controller readout data, combinational from `output_sel`.
- `done` in 1: multiply complete.

## Operation
- FSM states: IDLE, CLEAR, LOAD, WAIT, READ, RESP.
- **IDLE**
  - If any `req_valid` is high, select grant g, assert `req_ready[g]` combinationally, capture `req_a{g}`/`req_b{g}` and g, then go to CLEAR.
- **Arbitration**
  - Single request: that requester wins.
  - Both requesting: the requester not served last wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `last_grant` updates on accept.
- **CLEAR** (1 cycle)
  - `mmu_rst`=1, then go to LOAD.
- **LOAD** (8 cycles, beat k=0..7)
  - `load_en`=1, `load_sel_ab`=k[2], `load_index`=k[1:0].
  - `in_data` = A byte k[1:0] for k<4, B byte k[1:0] for k≥4.
  - After beat 7, go to WAIT.
- **WAIT**
  - Timeout counter cleared on entry, incremented each cycle.
  - `done`=1 sampled: go to READ.
  - Counter reaches `TIMEOUT_CYCLES`-1 with `done`=0: set error flag, clear result, go to RESP.
  - `done` takes priority over timeout in the same cycle.
- **READ** (4 cycles, beat j=0..3)
  - `output_en`=1, `output_sel`=j.
  - Capture `out_data` into result byte j at the end of the cycle.
  - Then go to RESP.
- **RESP**
  - `resp_valid[g]`=1, `resp_data`=result, `resp_err`=error flag, all held stable.
  - On `resp_ready[g]`=1: go to IDLE and clear the error flag.
  - `resp_ready` of the non-owner is ignored.
  - New requests are not accepted until IDLE.
- Outside their states, `load_en`, `output_en`, `in_data`, `load_index`, `load_sel_ab` and `output_sel` are 0.
- `mmu_rst` = `rst` OR (state==CLEAR).

## Timing
- Reset values:
  - State IDLE, `last_grant`=1.
  - `req_ready`, `resp_valid`, `resp_err`, `busy`, `load_en`, `output_en` = 0; `resp_data`=0.
  - `mmu_rst`=1 while `rst` is high.
- Accept at edge T. CLEAR occupies cycle T+1; LOAD occupies T+2..T+9; WAIT starts at T+10.
- `done` high in WAIT cycle W: READ occupies W+1..W+4; `resp_valid` rises at W+5.
- Minimum accept-to-`resp_valid` latency is 14 cycles, reached when `done` is already high in the first WAIT cycle.
- Timeout: `resp_valid` is asserted in the cycle after WAIT cycle `TIMEOUT_CYCLES`-1.
- Back-to-back: after response accept at edge R, IDLE is cycle R+1, so the earliest next `req_ready` is in cycle R+1.
- `rst` asserted in any state aborts the job:
  - next cycle is IDLE, no response is issued, partial result is discarded;
  - `mmu_rst` is high during reset, so the controller's loaded flags are cleared.
- `req_valid` may drop before grant without effect. The arbiter never asserts `req_ready` outside IDLE.

## Test plan
- **Single job:** requester 0, A=32'h01000001 (identity), B=32'h04030201.
  - 8 load beats carry 01,00,00,01,01,02,03,04 with `load_sel_ab` 0,0,0,0,1,1,1,1.
  - Response: `resp_valid`=2'b01, `resp_data`=32'h04030201, `resp_err`=0, earliest 14 cycles after accept.
- **Tie arbitration:** both requesters valid from reset.
  - Requester 0 served first, then requester 1.
  - Requester 1 gets A=32'h02000002, B=32'h01010101 and returns 32'h02020202.
- **Fairness:** requester 0 held valid continuously, requester 1 raised during job 0.
  - Grants alternate 0,1,0; requester 0 never wins twice while 1 waits.
- **Timeout:** stubbed MMU with `done` stuck 0, `TIMEOUT_CYCLES`=16.
  - `resp_err`=1, `resp_data`=0, READ never entered.
  - The next job's CLEAR pulses `mmu_rst`.
- **Backpressure:** `resp_ready` held 0 for 10 cycles, with a pending request on the other requester.
  - `resp_valid`/`resp_data` stable throughout; no `req_ready` until after response accept.
  - `resp_ready` asserted on the wrong requester bit is ignored.
- **Reset mid-LOAD:** `rst` pulsed at beat 4.
  - IDLE the following cycle, all outputs at reset values, no `resp_valid`.
  - A fresh job then completes correctly.
